// File: rtl/int2flt_if.sv
// Converter bus: start/busy/done handshake plus the byte-wide data_mem port.
// The master side is the converter; the slave side is the memory / controller.
interface int2flt_if;
    logic       start_i;
    logic [7:0] mem_addr_o;
    logic       mem_we_o;
    logic [7:0] mem_wdata_o;
    logic [7:0] mem_rdata_i;
    logic       busy_o;
    logic       done_o;

    modport master (
        input  start_i, mem_rdata_i,
        output mem_addr_o, mem_we_o, mem_wdata_o, busy_o, done_o
    );

    modport slave (
        output start_i, mem_rdata_i,
        input  mem_addr_o, mem_we_o, mem_wdata_o, busy_o, done_o
    );
endinterface

// File: rtl/int2flt.sv
// 16-bit integer to IEEE-754 half converter: byte loads, one-bit-per-cycle normalize, RNE round, byte stores.
// Define TWOS_COMP_IN_EN for two's-complement operands; the default build takes sign-magnitude.
module int2flt #(
    parameter logic [7:0] SRC_ADDR = 8'd64,
    parameter logic [7:0] DST_ADDR = 8'd66
) (
    input logic      clk_i,
    input logic      reset_i,
    int2flt_if.master bus
);
    typedef enum logic [2:0] {
        IDLE, LD_HI, LD_LO, NORM, ROUND, ST_HI, ST_LO, DONE
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  op_hi_q, op_hi_d;
    logic        sign_q, sign_d;
    logic [15:0] mag_q, mag_d;
    logic [4:0]  exp_q, exp_d;
    logic [15:0] result_q, result_d;

    logic [15:0] op;
    logic [15:0] ld_mag;

    // mag[15] is set on entry; a mantissa carry-out bumps the exponent.
    function automatic logic [15:0] round_rne(input logic s, input logic [4:0] e,
                                              input logic [15:0] m);
        logic [9:0]  mant;
        logic        guard;
        logic        sticky;
        logic [10:0] sum;
        logic [4:0]  e_out;
        mant   = m[14:5];
        guard  = m[4];
        sticky = |m[3:0];
        sum    = {1'b0, mant} + {10'd0, guard & (sticky | mant[0])};
        e_out  = e + {4'd0, sum[10]};
        return {s, e_out, sum[9:0]};
    endfunction

    assign op = {op_hi_q, bus.mem_rdata_i};

    always_comb begin
`ifdef TWOS_COMP_IN_EN
        ld_mag = op[15] ? (~op + 16'd1) : op;
`else
        ld_mag = {1'b0, op[14:0]};
`endif
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            op_hi_q  <= 8'd0;
            sign_q   <= 1'b0;
            mag_q    <= 16'd0;
            exp_q    <= 5'd0;
            result_q <= 16'd0;
        end else begin
            state_q  <= state_d;
            op_hi_q  <= op_hi_d;
            sign_q   <= sign_d;
            mag_q    <= mag_d;
            exp_q    <= exp_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_hi_d  = op_hi_q;
        sign_d   = sign_q;
        mag_d    = mag_q;
        exp_d    = exp_q;
        result_d = result_q;
        case (state_q)
            IDLE, DONE: if (bus.start_i) state_d = LD_HI;
            LD_HI: begin
                op_hi_d = bus.mem_rdata_i;
                state_d = LD_LO;
            end
            LD_LO: begin
                sign_d = op[15];
                mag_d  = ld_mag;
                exp_d  = 5'd30;
                // A zero magnitude would never normalize, so it bypasses NORM/ROUND.
                if (ld_mag == 16'd0) begin
                    result_d = {op[15], 15'd0};
                    state_d  = ST_HI;
                end else begin
                    state_d  = NORM;
                end
            end
            NORM: begin
                if (mag_q[15]) begin
                    state_d = ROUND;
                end else begin
                    mag_d = {mag_q[14:0], 1'b0};
                    exp_d = exp_q - 5'd1;
                end
            end
            ROUND: begin
                result_d = round_rne(sign_q, exp_q, mag_q);
                state_d  = ST_HI;
            end
            ST_HI:   state_d = ST_LO;
            ST_LO:   state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.mem_addr_o  = 8'd0;
        bus.mem_we_o    = 1'b0;
        bus.mem_wdata_o = 8'd0;
        bus.busy_o      = 1'b0;
        bus.done_o      = 1'b0;
        case (state_q)
            LD_HI: begin
                bus.mem_addr_o = SRC_ADDR;
                bus.busy_o     = 1'b1;
            end
            LD_LO: begin
                bus.mem_addr_o = SRC_ADDR + 8'd1;
                bus.busy_o     = 1'b1;
            end
            NORM, ROUND: bus.busy_o = 1'b1;
            ST_HI: begin
                bus.mem_addr_o  = DST_ADDR;
                bus.mem_we_o    = 1'b1;
                bus.mem_wdata_o = result_q[15:8];
                bus.busy_o      = 1'b1;
            end
            ST_LO: begin
                bus.mem_addr_o  = DST_ADDR + 8'd1;
                bus.mem_we_o    = 1'b1;
                bus.mem_wdata_o = result_q[7:0];
                bus.busy_o      = 1'b1;
            end
            DONE:    bus.done_o = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_int2flt.sv
// Directed bench for int2flt: table of operands with hand-computed half results and latencies,
// plus sequences for start-while-busy, done hold and reset during normalization.
module tb_int2flt;
    logic clk;
    logic reset_i;

    int2flt_if bus ();

    int2flt #(.SRC_ADDR(8'd64), .DST_ADDR(8'd66)) dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] src_mem [256];
    logic [7:0] dst_hi, dst_lo;
    int         hi_cnt, lo_cnt, other_cnt;

    assign bus.mem_rdata_i = src_mem[bus.mem_addr_o];

    initial begin
        hi_cnt = 0; lo_cnt = 0; other_cnt = 0;
        dst_hi = 8'h00; dst_lo = 8'h00;
    end

    always @(posedge clk) begin
        if (bus.mem_we_o) begin
            if (bus.mem_addr_o == 8'd66) begin
                dst_hi = bus.mem_wdata_o;
                hi_cnt = hi_cnt + 1;
            end else if (bus.mem_addr_o == 8'd67) begin
                dst_lo = bus.mem_wdata_o;
                lo_cnt = lo_cnt + 1;
            end else begin
                other_cnt = other_cnt + 1;
            end
        end
    end

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Runs one conversion; if inj_at >= 0, start_i is pulsed again while busy at that cycle.
    task automatic run(input logic [15:0] op, input int inj_at,
                       output int lat, output logic [15:0] res, output int nh, output int nl);
        int h0, l0;
        src_mem[64] = op[15:8];
        src_mem[65] = op[7:0];
        h0 = hi_cnt;
        l0 = lo_cnt;
        @(negedge clk);
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        lat = 0;
        while (!bus.done_o && lat < 100) begin
            bus.start_i = (lat == inj_at);
            @(negedge clk);
            lat++;
        end
        bus.start_i = 1'b0;
        res = {dst_hi, dst_lo};
        nh  = hi_cnt - h0;
        nl  = lo_cnt - l0;
    endtask

    typedef struct {
        logic [15:0] op;
        logic [15:0] res;
        int          lat;
    } vec_t;

    vec_t vecs [9];

    initial begin
        int          lat, nh, nl, h0, l0;
        logic [15:0] res;

        vecs[0] = '{16'h0001, 16'h3C00, 21};
        vecs[1] = '{16'h0801, 16'h6800, 10};
        vecs[2] = '{16'h0803, 16'h6802, 10};
        vecs[3] = '{16'h7FFF, 16'h7800, 7};
        vecs[4] = '{16'h0000, 16'h0000, 4};
        vecs[5] = '{16'h0005, 16'h4500, 19};
`ifdef TWOS_COMP_IN_EN
        vecs[6] = '{16'hFFFB, 16'hC500, 19};
        vecs[7] = '{16'h8000, 16'hF800, 6};
        vecs[8] = '{16'hFFFF, 16'hBC00, 21};
`else
        vecs[6] = '{16'h8005, 16'hC500, 19};
        vecs[7] = '{16'h8000, 16'h8000, 4};
        vecs[8] = '{16'hFFFF, 16'hF800, 7};
`endif

        for (int i = 0; i < 256; i++) src_mem[i] = 8'h00;
        bus.start_i = 1'b0;
        reset_i = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset addr",  {24'd0, bus.mem_addr_o},  32'd0);
        chk("reset we",    {31'd0, bus.mem_we_o},    32'd0);
        chk("reset wdata", {24'd0, bus.mem_wdata_o}, 32'd0);
        chk("reset busy",  {31'd0, bus.busy_o},      32'd0);
        chk("reset done",  {31'd0, bus.done_o},      32'd0);
        reset_i = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            run(vecs[i].op, -1, lat, res, nh, nl);
            chk($sformatf("result op=%04h", vecs[i].op), {16'd0, res}, {16'd0, vecs[i].res});
            chk($sformatf("latency op=%04h", vecs[i].op), lat, vecs[i].lat);
            chk($sformatf("hi writes op=%04h", vecs[i].op), nh, 1);
            chk($sformatf("lo writes op=%04h", vecs[i].op), nl, 1);
            chk($sformatf("busy at done op=%04h", vecs[i].op), {31'd0, bus.busy_o}, 32'd0);
        end

        // start pulsed while busy must not restart or add writes; done then holds.
        run(16'h0000, 2, lat, res, nh, nl);
        chk("busy-start result",  {16'd0, res}, 32'h0000);
        chk("busy-start latency", lat, 4);
        chk("busy-start writes",  nh + nl, 2);
        h0 = hi_cnt; l0 = lo_cnt;
        repeat (3) @(negedge clk);
        chk("done held", {31'd0, bus.done_o}, 32'd1);
        chk("no writes while done", (hi_cnt - h0) + (lo_cnt - l0), 0);
        chk("no stray writes", other_cnt, 0);

        // Reset in the middle of NORM: outputs drop at once, nothing reaches DST.
        src_mem[64] = 8'h00;
        src_mem[65] = 8'h01;
        h0 = hi_cnt; l0 = lo_cnt;
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (6) @(negedge clk);
        chk("busy in norm", {31'd0, bus.busy_o}, 32'd1);
        reset_i = 1'b1;
        #1;
        chk("mid reset busy", {31'd0, bus.busy_o},     32'd0);
        chk("mid reset done", {31'd0, bus.done_o},     32'd0);
        chk("mid reset addr", {24'd0, bus.mem_addr_o}, 32'd0);
        chk("mid reset we",   {31'd0, bus.mem_we_o},   32'd0);
        @(negedge clk);
        reset_i = 1'b0;
        repeat (25) @(negedge clk);
        chk("no dst write after reset", (hi_cnt - h0) + (lo_cnt - l0), 0);
        chk("idle after reset", {30'd0, bus.busy_o, bus.done_o}, 32'd0);

        run(16'h0005, -1, lat, res, nh, nl);
        chk("post-reset result",  {16'd0, res}, 32'h4500);
        chk("post-reset latency", lat, 19);
        chk("post-reset writes",  nh + nl, 2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
